// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully connected layer: one MAC reused across channels and neurons.
// Optional output ReLU enabled by defining NEURON_LAYER_SEQ_RELU_EN.
module neuron_layer_seq #(
  parameter int WidthIn     = 1,
  parameter int WidthOut    = 16,
  parameter int WeightWidth = 2,
  parameter int BiasWidth   = 8,
  parameter int InChannels  = 4,
  parameter int OutChannels = 2,
  parameter logic [OutChannels*InChannels*WeightWidth-1:0] Weights = '0,
  parameter logic [OutChannels*BiasWidth-1:0]              Biases  = '0,
  localparam int NeuronW = (OutChannels > 1) ? $clog2(OutChannels) : 1,
  localparam int ChanW   = (InChannels > 1) ? $clog2(InChannels) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [InChannels*WidthIn-1:0] data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WidthOut-1:0]           data_o,
  output logic [NeuronW-1:0]            neuron_o,
  output logic                          last_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_e;

  state_e                        state_q, state_d;
  logic signed [WidthOut-1:0]    acc_q, acc_d;
  logic [InChannels*WidthIn-1:0] x_q, x_d;
  logic [ChanW-1:0]              ch_q, ch_d;
  logic [NeuronW-1:0]            out_q, out_d;
  logic [WidthIn-1:0]            x_ch;
  logic signed [WidthOut-1:0]    prod;

  function automatic logic signed [WidthOut-1:0] weight_ext(input int o, input int ch);
    logic signed [WeightWidth-1:0] w;
    w = Weights[(o*InChannels+ch)*WeightWidth +: WeightWidth];
    return WidthOut'(w);
  endfunction

  function automatic logic signed [WidthOut-1:0] bias_ext(input int o);
    logic signed [BiasWidth-1:0] b;
    b = Biases[o*BiasWidth +: BiasWidth];
    return WidthOut'(b);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      x_q     <= '0;
      ch_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      ch_q    <= ch_d;
      out_q   <= out_d;
    end
  end

  // Inputs are unsigned, so the channel value is zero-extended before the signed multiply.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    ch_d    = ch_q;
    out_d   = out_q;
    x_ch    = x_q[ch_q*WidthIn +: WidthIn];
    prod    = weight_ext(int'(out_q), int'(ch_q)) * signed'(WidthOut'(x_ch));

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          x_d     = data_i;
          acc_d   = bias_ext(0);
          ch_d    = '0;
          out_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + prod;
        ch_d  = ch_q + ChanW'(1);
        if (ch_q == ChanW'(InChannels - 1)) begin
          ch_d    = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ready_i) begin
          if (out_q == NeuronW'(OutChannels - 1)) begin
            state_d = IDLE;
          end else begin
            out_d   = out_q + NeuronW'(1);
            ch_d    = '0;
            acc_d   = bias_ext(int'(out_q) + 1);
            state_d = ACCUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == EMIT);
  assign neuron_o = out_q;
  assign last_o   = (state_q == EMIT) && (out_q == NeuronW'(OutChannels - 1));

`ifdef NEURON_LAYER_SEQ_RELU_EN
  assign data_o = acc_q[WidthOut-1] ? '0 : acc_q;
`else
  assign data_o = acc_q;
`endif

endmodule
